// File: rtl/carrier_gen_ncarr_pkg.sv
// Shared PWM carrier definitions: count/mask modes, on/off flags and
// default widths used by the multi-carrier generator.
package PKG_pwm;

    typedef enum logic [1:0] {
        CM_UP     = 2'd0,
        CM_DOWN   = 2'd1,
        CM_UPDOWN = 2'd2,
        CM_RSVD   = 2'd3
    } cmode_e;

    typedef enum logic [1:0] {
        MM_MIN    = 2'd0,
        MM_MAX    = 2'd1,
        MM_MINMAX = 2'd2,
        MM_RSVD   = 2'd3
    } mmode_e;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } onoff_e;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_NCARR     = 4;
    localparam int DEF_EVT_WIDTH = 4;

endpackage

// File: rtl/carrier_gen_ncarr_cnt.sv
// One carrier counter with direction flag; period and mode come
// from the shadow registers in the top.
module carrier_cnt_core
    import PKG_pwm::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_init,
    input  cmode_e           i_mode,
    output logic [WIDTH-1:0] o_carrier,
    output logic             o_dir
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_c;
    logic             r_d;
    logic [WIDTH-1:0] w_nc;
    logic             w_nd;
    logic             w_up;
    logic             w_down;

    assign w_up   = (i_mode == CM_UP);
    assign w_down = (i_mode == CM_DOWN);

    always_comb begin
        w_nc = r_c;
        w_nd = r_d;
        if (!i_run) begin
            w_nc = (i_init > i_period) ? i_period : i_init;
            w_nd = !w_down;
        end else if (i_period == '0) begin
            w_nc = '0;
            w_nd = !w_down;
        end else if (r_c > i_period) begin
            // period shrank below the current count
            w_nc = w_up ? '0 : i_period;
            w_nd = w_up;
        end else if (w_up) begin
            w_nc = (r_c == i_period) ? '0 : r_c + ONE;
            w_nd = 1'b1;
        end else if (w_down) begin
            w_nc = (r_c == '0) ? i_period : r_c - ONE;
            w_nd = 1'b0;
        end else if (r_d) begin
            if (r_c >= i_period) begin
                w_nc = r_c - ONE;
                w_nd = 1'b0;
            end else begin
                w_nc = r_c + ONE;
            end
        end else if (r_c == '0) begin
            w_nc = r_c + ONE;
            w_nd = 1'b1;
        end else begin
            w_nc = r_c - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c <= '0;
            r_d <= 1'b1;
        end else begin
            r_c <= w_nc;
            r_d <= w_nd;
        end
    end

    assign o_carrier = r_c;
    assign o_dir     = r_d;

endmodule

// File: rtl/carrier_gen_ncarr.sv
// Multi-carrier generator: NCARR phase-shifted counters sharing one
// period, with decimated mask event, shadowed config and irq.
module carrier_gen_ncarr
    import PKG_pwm::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NCARR     = DEF_NCARR,
    parameter int EVT_WIDTH = DEF_EVT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       period,
    input  logic [NCARR*WIDTH-1:0] initcarr,
    input  logic [EVT_WIDTH-1:0]   eventcount,
    input  logic [1:0]             countmode,
    input  logic [1:0]             maskmode,
    input  logic                   pwm_onoff,
    input  logic                   carr_onoff,
    input  logic                   int_onoff,
    output logic [NCARR*WIDTH-1:0] carrier,
    output logic [NCARR-1:0]       dir,
    output logic                   maskevent,
    output logic                   irq
);

    logic [WIDTH-1:0]       r_period;
    logic [NCARR*WIDTH-1:0] r_init;
    logic [EVT_WIDTH-1:0]   r_evt_lim;
    cmode_e                 r_cmode;
    mmode_e                 r_mmode;
    logic [EVT_WIDTH-1:0]   r_evt;
    logic                   r_mask;
    logic                   r_irq;

    logic [WIDTH-1:0] w_c0;
    logic             w_pt;
    logic             w_single;
    logic             w_fire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_period  <= '0;
            r_init    <= '0;
            r_evt_lim <= '0;
            r_cmode   <= CM_UP;
            r_mmode   <= MM_MIN;
        end else if (!pwm_onoff || r_mask) begin
            r_period  <= period;
            r_init    <= initcarr;
            r_evt_lim <= eventcount;
            r_cmode   <= cmode_e'(countmode);
            r_mmode   <= mmode_e'(maskmode);
        end
    end

    for (genvar g = 0; g < NCARR; g++) begin : g_cnt
        carrier_cnt_core #(
            .WIDTH(WIDTH)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .i_run     (carr_onoff),
            .i_period  (r_period),
            .i_init    (r_init[g*WIDTH+:WIDTH]),
            .i_mode    (r_cmode),
            .o_carrier (carrier[g*WIDTH+:WIDTH]),
            .o_dir     (dir[g])
        );
    end

    assign w_c0 = carrier[WIDTH-1:0];

    always_comb begin
        w_pt = 1'b0;
        unique case (r_mmode)
            MM_MIN:    w_pt = (w_c0 == '0);
            MM_MAX:    w_pt = (w_c0 == r_period);
            MM_MINMAX: w_pt = (w_c0 == '0) || (w_c0 == r_period);
            MM_RSVD:   w_pt = (w_c0 == '0) || (w_c0 == r_period);
        endcase
    end

    assign w_single = carr_onoff & pwm_onoff & w_pt;
    assign w_fire   = w_single & (r_evt >= r_evt_lim);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_evt  <= '0;
            r_mask <= 1'b0;
            r_irq  <= 1'b0;
        end else begin
            r_mask <= w_fire;
            r_irq  <= w_fire & int_onoff;
            if (!carr_onoff || !pwm_onoff) begin
                r_evt <= '0;
            end else if (w_single) begin
                r_evt <= w_fire ? '0 : r_evt + EVT_WIDTH'(1);
            end
        end
    end

    assign maskevent = r_mask;
    assign irq       = r_irq;

endmodule

// File: tb/tb_carrier_gen_ncarr.sv
// Directed bench for carrier_gen_ncarr: counting modes, decimation,
// shadow timing, hold, irq gating and asynchronous reset.
module tb_carrier_gen_ncarr;

    localparam int W = 16;
    localparam int N = 4;
    localparam int E = 4;

    logic           clk;
    logic           reset;
    logic [W-1:0]   period;
    logic [N*W-1:0] initcarr;
    logic [E-1:0]   eventcount;
    logic [1:0]     countmode;
    logic [1:0]     maskmode;
    logic           pwm_onoff;
    logic           carr_onoff;
    logic           int_onoff;
    logic [N*W-1:0] carrier;
    logic [N-1:0]   dir;
    logic           maskevent;
    logic           irq;

    int n_chk  = 0;
    int n_fail = 0;

    carrier_gen_ncarr #(
        .WIDTH(W),
        .NCARR(N),
        .EVT_WIDTH(E)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .period     (period),
        .initcarr   (initcarr),
        .eventcount (eventcount),
        .countmode  (countmode),
        .maskmode   (maskmode),
        .pwm_onoff  (pwm_onoff),
        .carr_onoff (carr_onoff),
        .int_onoff  (int_onoff),
        .carrier    (carrier),
        .dir        (dir),
        .maskevent  (maskevent),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] car(input int i);
        return carrier[i*W+:W];
    endfunction

    task automatic cfg(input int p, input int i0, input int i1,
                       input int i2, input int i3, input int cm,
                       input int mm, input int ec);
        period     = W'(p);
        initcarr   = {W'(i3), W'(i2), W'(i1), W'(i0)};
        countmode  = 2'(cm);
        maskmode   = 2'(mm);
        eventcount = E'(ec);
    endtask

    // transparent shadows, counters parked at their start values
    task automatic preload();
        pwm_onoff  = 1'b0;
        carr_onoff = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_ud(input string tag);
        int e0[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        int e1[8] = '{3, 4, 3, 2, 1, 0, 1, 2};
        int e2[8] = '{3, 2, 1, 0, 1, 2, 3, 4};
        int e3[8] = '{2, 3, 4, 3, 2, 1, 0, 1};
        int d0[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            tick();
            check({tag, "_c0"}, 32'(car(0)), 32'(e0[i]));
            check({tag, "_c1"}, 32'(car(1)), 32'(e1[i]));
            check({tag, "_c2"}, 32'(car(2)), 32'(e2[i]));
            check({tag, "_c3"}, 32'(car(3)), 32'(e3[i]));
            check({tag, "_d0"}, 32'(dir[0]), 32'(d0[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_c;
        reset      = 1'b0;
        pwm_onoff  = 1'b0;
        carr_onoff = 1'b0;
        int_onoff  = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_car", 32'(carrier != '0), 32'd0);
        check("rst_dir", 32'(dir), 32'hF);
        check("rst_mask", 32'(maskevent), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        tick();
        reset = 1'b1;

        // UPDOWN, P=4, phases 0/2/4/1
        cfg(4, 0, 2, 4, 1, 2, 2, 0);
        preload();
        check("ud_init_c0", 32'(car(0)), 32'd0);
        check("ud_init_c2", 32'(car(2)), 32'd4);
        carr_onoff = 1'b1;
        run_ud("ud");

        // UP, P=3, MIN, skip 2 -> one pulse per 12 clocks
        cfg(3, 0, 0, 0, 0, 0, 0, 2);
        preload();
        carr_onoff = 1'b1;
        pwm_onoff  = 1'b1;
        for (int t = 1; t <= 36; t++) begin
            tick();
            check("dec_c0", 32'(car(0)), 32'(t % 4));
            check("dec_mask", 32'(maskevent),
                  32'(t == 9 || t == 21 || t == 33));
            check("dec_irq", 32'(irq), 32'(t == 33));
            if (t == 24) int_onoff = 1'b1;
        end
        int_onoff = 1'b0;

        // period rewrite only lands after the next mask event
        cfg(10, 0, 0, 0, 0, 0, 0, 0);
        preload();
        carr_onoff = 1'b1;
        pwm_onoff  = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            if (t <= 10)      exp_c = t;
            else if (t == 11) exp_c = 0;
            else if (t <= 17) exp_c = t - 11;
            else              exp_c = 0;
            check("shd_c0", 32'(car(0)), 32'(exp_c));
            check("shd_mask", 32'(maskevent), 32'(t == 1 || t == 12));
            if (t == 4) period = W'(6);
        end

        // DOWN, init clamped to P while held
        cfg(5, 7, 0, 3, 9, 1, 0, 0);
        preload();
        check("dn_hold_c0", 32'(car(0)), 32'd5);
        check("dn_hold_c1", 32'(car(1)), 32'd0);
        check("dn_hold_c2", 32'(car(2)), 32'd3);
        check("dn_hold_c3", 32'(car(3)), 32'd5);
        check("dn_hold_dir", 32'(dir), 32'd0);
        tick();
        tick();
        check("dn_hold2_c0", 32'(car(0)), 32'd5);
        carr_onoff = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            check("dn_c0", 32'(car(0)), 32'(t == 6 ? 5 : 5 - t));
            check("dn_d0", 32'(dir[0]), 32'd0);
        end

        // asynchronous reset mid-UPDOWN, then restart
        cfg(4, 0, 2, 4, 1, 2, 2, 0);
        preload();
        carr_onoff = 1'b1;
        pwm_onoff  = 1'b1;
        int_onoff  = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_c0", 32'(car(0)), 32'd3);
        reset = 1'b0;
        #2;
        check("arst_car", 32'(carrier != '0), 32'd0);
        check("arst_dir", 32'(dir), 32'hF);
        check("arst_mask", 32'(maskevent), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        tick();
        check("rst_hold_car", 32'(carrier != '0), 32'd0);
        reset     = 1'b1;
        int_onoff = 1'b0;
        preload();
        check("re_init_c0", 32'(car(0)), 32'd0);
        check("re_init_c2", 32'(car(2)), 32'd4);
        carr_onoff = 1'b1;
        run_ud("re");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
